rpn_stack_controller: RTL and testbench

- Sequences the RPN evaluation datapath: consumes parsed number and operator events from the UART interpreter front end and drives an operand stack plus a multi-cycle ALU.
- Sits between the interpreter (num_ready/num, op_ready/op) and the result/transmit path.
- Owns stack-pointer bookkeeping, operand fetch, ALU scheduling (including an iterative divider), writeback and error reporting.

---
 rtl/rpn_stack_controller.sv | 249 ++++++++++++++++++++++++
 tb/tb_rpn_stack_controller.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_controller.sv
// rpn_stack_controller
//   Sequencer for the RPN calculator datapath. It takes parsed number and
//   operator events from the interpreter, keeps the operand stack, runs the
//   ALU (single-cycle add/sub/mul, 16-cycle restoring divider), writes the
//   result back and reports errors.
//
//   Optional build macro: RPN_AUTO_EMIT_EN
//     defined   : every writeback also drives result/result_valid.
//     undefined : result/result_valid change only on '='.
//
//   Event handshake: num_ready and op_ready are single-cycle strobes with no
//   back-pressure. An event is consumed only while the sequencer is idle
//   (busy low). An event that arrives while busy is high is discarded and
//   reported with a one-cycle dropped pulse.
//
//   Ports
//     clk, rst      clock, asynchronous active-high reset
//     num_ready/num number event strobe and 16-bit operand
//     op_ready/op   operator event strobe and code (1 + 2 - 3 * 4 / 5 = 6 C)
//     result        last emitted value, result_valid one-cycle pulse
//     depth         current stack occupancy
//     busy          high while an operation (or a pending op) is in flight
//     err/err_code  one-cycle error pulse and sticky code (1 under, 2 over,
//                   3 divide by zero)
//     dropped       one-cycle pulse for an event discarded while busy
module rpn_stack_controller #(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          num_ready,
  input  logic [15:0]   num,
  input  logic          op_ready,
  input  logic [3:0]    op,
  output logic [15:0]   result,
  output logic          result_valid,
  output logic [DW-1:0] depth,
  output logic          busy,
  output logic          err,
  output logic [1:0]    err_code,
  output logic          dropped
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_EMIT  = 4'd5;
  localparam logic [3:0] OP_CLEAR = 4'd6;

  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_DIV0  = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, WB} state_t;

  state_t        state;
  logic [15:0]   stack [DEPTH];
  logic          pend_valid;
  logic [3:0]    pend_op;
  logic [3:0]    cur_op;
  logic [15:0]   acc;      // ALU result, doubles as dividend/quotient shifter
  logic [15:0]   rem;      // partial remainder of the divider
  logic [3:0]    div_cnt;

  logic [AW-1:0] top_idx;
  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] push_idx;
  logic [15:0]   opnd_a;
  logic [15:0]   opnd_b;
  logic [16:0]   div_trial;
  logic          is_full;
  logic          push_en;
  logic          eval_go;
  logic [3:0]    eval_code;
  logic          stack_we;
  logic [AW-1:0] stack_waddr;
  logic [15:0]   stack_wdata;

  function automatic logic op_known(input logic [3:0] code);
    return (code >= OP_ADD) && (code <= OP_CLEAR);
  endfunction

  // depth == DEPTH wraps to index 0 after truncation, so depth-1 still
  // addresses the top entry when the stack is full.
  assign top_idx  = AW'(depth - DW'(1));
  assign nxt_idx  = AW'(depth - DW'(2));
  assign push_idx = AW'(depth);
  assign is_full  = (depth == DW'(DEPTH));
  assign opnd_b   = stack[top_idx];
  assign opnd_a   = stack[nxt_idx];

  // Trial subtraction of the shifted partial remainder.
  assign div_trial = {rem, acc[15]} - {1'b0, opnd_b};

  // A pending op has priority in IDLE; otherwise a lone op_ready is evaluated
  // straight away (a simultaneous num_ready turns it into a pending op).
  assign eval_go   = (state == IDLE) && (pend_valid || (op_ready && !num_ready));
  assign eval_code = pend_valid ? pend_op : op;
  assign push_en   = (state == IDLE) && !pend_valid && num_ready && !is_full;

  assign busy = (state != IDLE) || pend_valid;

  always_comb begin
    stack_we    = 1'b0;
    stack_waddr = push_idx;
    stack_wdata = num;
    if (push_en) begin
      stack_we = 1'b1;
    end else if (state == WB) begin
      stack_we    = 1'b1;
      stack_waddr = nxt_idx;
      stack_wdata = acc;
    end
  end

  // Stack contents need no reset; only depth defines which entries are live.
  always_ff @(posedge clk) begin
    if (stack_we) stack[stack_waddr] <= stack_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      depth        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
      dropped      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_op      <= '0;
      cur_op       <= '0;
      acc          <= '0;
      rem          <= '0;
      div_cnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      dropped      <= 1'b0;

      if ((state != IDLE) && (num_ready || op_ready)) dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (pend_valid) begin
            pend_valid <= 1'b0;
            if (num_ready || op_ready) dropped <= 1'b1;
          end else if (num_ready) begin
            if (is_full) begin
              err      <= 1'b1;
              err_code <= ERR_OVER;
            end else begin
              depth <= depth + DW'(1);
            end
            if (op_ready && op_known(op)) begin
              pend_valid <= 1'b1;
              pend_op    <= op;
            end
          end

          if (eval_go) begin
            case (eval_code)
              OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                if (depth >= DW'(2)) begin
                  cur_op <= eval_code;
                  state  <= EXEC;
                end else begin
                  err      <= 1'b1;
                  err_code <= ERR_UNDER;
                end
              end
              OP_EMIT: begin
                if (depth != '0) begin
                  result       <= opnd_b;
                  result_valid <= 1'b1;
                end else begin
                  err      <= 1'b1;
                  err_code <= ERR_UNDER;
                end
              end
              OP_CLEAR: depth <= '0;
              default: ;
            endcase
          end
        end

        EXEC: begin
          case (cur_op)
            OP_ADD: begin
              acc   <= opnd_a + opnd_b;
              state <= WB;
            end
            OP_SUB: begin
              acc   <= opnd_a - opnd_b;
              state <= WB;
            end
            OP_MUL: begin
              acc   <= opnd_a * opnd_b;
              state <= WB;
            end
            default: begin
              if (opnd_b == '0) begin
                err      <= 1'b1;
                err_code <= ERR_DIV0;
                state    <= IDLE;
              end else begin
                acc     <= opnd_a;
                rem     <= '0;
                div_cnt <= '0;
                state   <= DIV;
              end
            end
          endcase
        end

        DIV: begin
          // When the trial goes negative rem[15] must be 0 (otherwise the
          // shifted value would exceed any 16-bit divisor), so the plain
          // shift loses nothing.
          if (!div_trial[16]) begin
            rem <= div_trial[15:0];
            acc <= {acc[14:0], 1'b1};
          end else begin
            rem <= {rem[14:0], acc[15]};
            acc <= {acc[14:0], 1'b0};
          end
          div_cnt <= div_cnt + 4'd1;
          if (div_cnt == 4'd15) state <= WB;
        end

        WB: begin
          depth <= depth - DW'(1);
          state <= IDLE;
`ifdef RPN_AUTO_EMIT_EN
          result       <= acc;
          result_valid <= 1'b1;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_controller.sv
// tb_rpn_stack_controller
//   Self-checking bench for rpn_stack_controller: directed scenarios with
//   literal expectations, then a randomized event stream. A queue-based
//   stack model predicts every output each cycle; emitted results are also
//   tracked through an expected queue.
module tb_rpn_stack_controller;

  localparam int DEPTH = 8;
  localparam int DW    = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          num_ready = 1'b0;
  logic [15:0]   num = '0;
  logic          op_ready = 1'b0;
  logic [3:0]    op = '0;
  logic [15:0]   result;
  logic          result_valid;
  logic [DW-1:0] depth;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;
  logic          dropped;

  always #5 clk = ~clk;

  rpn_stack_controller #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .num_ready(num_ready), .num(num),
    .op_ready(op_ready), .op(op),
    .result(result), .result_valid(result_valid),
    .depth(depth), .busy(busy),
    .err(err), .err_code(err_code), .dropped(dropped)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // The stack is a queue; an accepted binary op computes its value at once
  // and only the moment it takes effect is delayed by a countdown.
  logic [15:0] m_stk[$];
  logic [15:0] exp_q[$];
  int          m_timer;
  bit          m_pend;
  logic [3:0]  m_pend_op;
  bit          m_act_err;
  logic [15:0] m_val;
  logic [15:0] e_result;
  bit          e_rv, e_err, e_drop;
  logic [1:0]  e_ec;

  task automatic m_underflow();
    e_err = 1'b1;
    e_ec  = 2'd1;
  endtask

  task automatic m_eval(input logic [3:0] code);
    logic [15:0] a, b;
    logic [31:0] p;
    case (code)
      4'd1, 4'd2, 4'd3, 4'd4: begin
        if (m_stk.size() < 2) m_underflow();
        else begin
          a = m_stk[m_stk.size()-2];
          b = m_stk[m_stk.size()-1];
          m_act_err = 1'b0;
          m_timer   = 2;
          case (code)
            4'd1: m_val = a + b;
            4'd2: m_val = a - b;
            4'd3: begin p = a * b; m_val = p[15:0]; end
            default: begin
              if (b == 16'd0) begin m_act_err = 1'b1; m_timer = 1; end
              else begin m_val = a / b; m_timer = 18; end
            end
          endcase
        end
      end
      4'd5: begin
        if (m_stk.size() >= 1) begin
          e_result = m_stk[m_stk.size()-1];
          e_rv = 1'b1;
          exp_q.push_back(e_result);
        end else m_underflow();
      end
      4'd6: m_stk.delete();
      default: ;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stk.delete(); exp_q.delete();
      m_timer = 0; m_pend = 1'b0; m_pend_op = '0; m_act_err = 1'b0; m_val = '0;
      e_result = '0; e_rv = 1'b0; e_err = 1'b0; e_drop = 1'b0; e_ec = '0;
    end else begin
      e_rv = 1'b0; e_err = 1'b0; e_drop = 1'b0;
      if (m_timer > 0) begin
        if (num_ready || op_ready) e_drop = 1'b1;
        m_timer--;
        if (m_timer == 0) begin
          if (m_act_err) begin
            e_err = 1'b1;
            e_ec  = 2'd3;
          end else begin
            void'(m_stk.pop_back());
            void'(m_stk.pop_back());
            m_stk.push_back(m_val);
`ifdef RPN_AUTO_EMIT_EN
            e_result = m_val;
            e_rv = 1'b1;
            exp_q.push_back(m_val);
`endif
          end
        end
      end else if (m_pend) begin
        m_pend = 1'b0;
        if (num_ready || op_ready) e_drop = 1'b1;
        m_eval(m_pend_op);
      end else begin
        if (num_ready) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(num);
          else begin e_err = 1'b1; e_ec = 2'd2; end
          if (op_ready && op >= 4'd1 && op <= 4'd6) begin
            m_pend = 1'b1;
            m_pend_op = op;
          end
        end else if (op_ready) begin
          m_eval(op);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking && !rst) begin
      check("depth", int'(depth), m_stk.size());
      check("busy", int'(busy), int'((m_timer > 0) || m_pend));
      check("result", int'(result), int'(e_result));
      check("result_valid", int'(result_valid), int'(e_rv));
      check("err", int'(err), int'(e_err));
      check("err_code", int'(err_code), int'(e_ec));
      check("dropped", int'(dropped), int'(e_drop));
      if (result_valid) begin
        if (exp_q.size() == 0) check("emit_unexpected", int'(result), -1);
        else check("emit_queue", int'(result), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit nr, input logic [15:0] n, input bit orr, input logic [3:0] o);
    num_ready = nr; num = n; op_ready = orr; op = o;
    @(negedge clk);
    num_ready = 1'b0; op_ready = 1'b0;
  endtask

  task automatic send_num(input logic [15:0] n); drive(1'b1, n, 1'b0, 4'd0); endtask
  task automatic send_op(input logic [3:0] o);  drive(1'b0, 16'd0, 1'b1, o); endtask
  task automatic idle(input int n); repeat (n) drive(1'b0, 16'd0, 1'b0, 4'd0); endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin idle(1); n++; end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_depth"}, int'(depth), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_dropped"}, int'(dropped), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int r;
    bit nr, orr;
    logic [3:0] oc;
    logic [15:0] nv;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    checking = 1'b1;

    // 12 34 + =  -> 46
    send_num(16'd12); send_num(16'd34);
    check("push_two_depth", int'(depth), 2);
    send_op(4'd1);
    check("add_busy", int'(busy), 1);
    idle(2);
    check("add_wb_depth", int'(depth), 1);
    send_op(4'd5);
    check("add_result", int'(result), 46);
    check("add_rv", int'(result_valid), 1);
    check("model_add_ref", int'(e_result), 46);

    // 5 9 - = -> 0xFFFC ; 300 300 * = -> 0x5F90
    send_op(4'd6);
    send_num(16'd5); send_num(16'd9); send_op(4'd2); idle(2); send_op(4'd5);
    check("sub_wrap", int'(result), 16'hFFFC);
    send_num(16'd300); send_num(16'd300); send_op(4'd3); idle(2); send_op(4'd5);
    check("mul_low16", int'(result), 16'h5F90);
    check("model_mul_ref", int'(e_result), 16'h5F90);

    // 1000 7 / -> writeback 18 edges after the op, then = -> 142
    send_op(4'd6);
    send_num(16'd1000); send_num(16'd7); send_op(4'd4);
    n = 0;
    while (depth != 1 && n < 40) begin idle(1); n++; end
    check("div_latency", n, 18);
    check("div_idle_after", int'(busy), 0);
    send_op(4'd5);
    check("div_result", int'(result), 142);

    // divide by zero
    send_op(4'd6);
    send_num(16'd5); send_num(16'd0); send_op(4'd4); idle(1);
    check("div0_err", int'(err), 1);
    check("div0_code", int'(err_code), 3);
    check("div0_depth", int'(depth), 2);
    idle(1);

    // underflow on empty stack
    send_op(4'd6); send_op(4'd1);
    check("under_err", int'(err), 1);
    check("under_code", int'(err_code), 1);
    check("under_depth", int'(depth), 0);

    // overflow: DEPTH+1 pushes
    send_op(4'd6);
    for (int i = 0; i <= DEPTH; i++) send_num(16'(i + 1));
    check("over_err", int'(err), 1);
    check("over_code", int'(err_code), 2);
    check("over_depth", int'(depth), DEPTH);

    // simultaneous num and op: 3, then (4,+) -> 7
    send_op(4'd6);
    send_num(16'd3);
    drive(1'b1, 16'd4, 1'b1, 4'd1);
    check("simul_depth", int'(depth), 2);
    check("simul_busy", int'(busy), 1);
    idle(3);
    check("simul_wb_depth", int'(depth), 1);
    send_op(4'd5);
    check("simul_result", int'(result), 7);

    // num strobe during a divide is dropped
    send_op(4'd6);
    send_num(16'd9); send_num(16'd2); send_op(4'd4); idle(3);
    send_num(16'd77);
    check("drop_pulse", int'(dropped), 1);
    check("drop_depth", int'(depth), 2);
    wait_idle();
    send_op(4'd5);
    check("drop_div_result", int'(result), 4);

    // reset in the middle of a divide
    send_op(4'd6);
    send_num(16'd100); send_num(16'd3); send_op(4'd4); idle(9);
    #1 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // 2 3 + after reset: auto emit only when the feature is built in
    send_num(16'd2); send_num(16'd3); send_op(4'd1); idle(2);
`ifdef RPN_AUTO_EMIT_EN
    check("auto_emit_rv", int'(result_valid), 1);
    check("auto_emit_result", int'(result), 5);
`else
    check("no_auto_emit_rv", int'(result_valid), 0);
    check("no_auto_emit_result", int'(result), 0);
`endif
    check("post_rst_depth", int'(depth), 1);

    // randomized event stream
    send_op(4'd6);
    for (int i = 0; i < 3000; i++) begin
      nr  = ($urandom_range(0, 9) < 3);
      orr = ($urandom_range(0, 9) < 3);
      r   = $urandom_range(0, 19);
      if (r < 4)       oc = 4'd1;
      else if (r < 7)  oc = 4'd2;
      else if (r < 10) oc = 4'd3;
      else if (r < 14) oc = 4'd4;
      else if (r < 16) oc = 4'd5;
      else if (r < 17) oc = 4'd6;
      else if (r < 18) oc = 4'd0;
      else             oc = 4'($urandom_range(7, 15));
      if ($urandom_range(0, 3) == 0) nv = 16'($urandom_range(0, 3));
      else nv = 16'($urandom_range(0, 65535));
      drive(nr, nv, orr, oc);
    end
    wait_idle();
    idle(2);
    check("emit_queue_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
